gbuf_stream_reader: RTL and testbench

- Read-side sequencer directly downstream of the global buffer.
- On a start command it issues a contiguous run of reads to the buffer's shared index/wr_en port and captures the 1-cycle-latency data_out.
- It streams the words to the consumer (systolic-array feeder) over a valid/ready handshake, using a 2-entry skid FIFO to absorb backpressure.

---
 rtl/gbuf_rd_pkg.sv | 14 +
 rtl/gbuf_skid_fifo.sv | 65 ++++++
 rtl/gbuf_stream_reader.sv | 131 +++++++++++++
 tb/tb_gbuf_stream_reader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gbuf_rd_pkg.sv
// Shared types and constants for the global-buffer stream reader.
package gbuf_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int FIFO_DEPTH    = 2;
   localparam int FIFO_CNT_BITS = 2;

endpackage

// File: rtl/gbuf_skid_fifo.sv
// Two-entry register FIFO; slot0 is always the head so the output is straight from a flop.
module gbuf_skid_fifo
   import gbuf_rd_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DATA_BITS-1:0]     push_data,
   input  logic                     pop,
   output logic                     head_valid,
   output logic [DATA_BITS-1:0]     head_data,
   output logic [FIFO_CNT_BITS-1:0] count
);

   logic [DATA_BITS-1:0]     slot0_q, slot0_d;
   logic [DATA_BITS-1:0]     slot1_q, slot1_d;
   logic [FIFO_CNT_BITS-1:0] count_q, count_d;
   logic [FIFO_CNT_BITS-1:0] kept_s;
   logic                     pop_s;
   logic                     push_s;

   // Next-state: pop shifts slot1 forward, push lands in the first free slot after the pop.
   always_comb begin
      pop_s   = pop & (count_q != FIFO_CNT_BITS'(0));
      push_s  = push & ((count_q != FIFO_CNT_BITS'(FIFO_DEPTH)) | pop_s);
      kept_s  = count_q - FIFO_CNT_BITS'(pop_s);
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      if (pop_s) begin
         slot0_d = slot1_q;
      end else begin
         slot0_d = slot0_q;
      end
      if (push_s) begin
         if (kept_s == FIFO_CNT_BITS'(0)) begin
            slot0_d = push_data;
         end else begin
            slot1_d = push_data;
         end
      end else begin
         slot1_d = slot1_q;
      end
      count_d = kept_s + FIFO_CNT_BITS'(push_s);
   end

   // Storage and occupancy registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= '0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

   assign head_valid = (count_q != FIFO_CNT_BITS'(0));
   assign head_data  = slot0_q;
   assign count      = count_q;

endmodule

// File: rtl/gbuf_stream_reader.sv
// Issues a contiguous run of global-buffer reads and streams the captured words
// to a valid/ready consumer through a two-entry skid FIFO.
module gbuf_stream_reader
   import gbuf_rd_pkg::*;
#(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] base_addr,
   input  logic [ADDR_BITS:0]   len,
   output logic                 busy,
   output logic                 done,
   output logic                 gb_wr_en,
   output logic [ADDR_BITS-1:0] gb_index,
   input  logic [DATA_BITS-1:0] gb_data_out,
   output logic                 m_valid,
   output logic [DATA_BITS-1:0] m_data,
   output logic                 m_last,
   input  logic                 m_ready
);

   state_e                   state_q, state_d;
   logic [ADDR_BITS-1:0]     addr_q, addr_d;
   logic [ADDR_BITS:0]       remaining_q, remaining_d;
   logic [ADDR_BITS:0]       beats_q, beats_d;
   logic                     inflight_q, inflight_d;
   logic                     issue_s;
   logic                     pop_s;
   logic                     credit_s;
   logic                     head_valid_s;
   logic [DATA_BITS-1:0]     head_data_s;
   logic [FIFO_CNT_BITS-1:0] fifo_count_s;

   gbuf_skid_fifo #(.DATA_BITS(DATA_BITS)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (inflight_q),
      .push_data  (gb_data_out),
      .pop        (pop_s),
      .head_valid (head_valid_s),
      .head_data  (head_data_s),
      .count      (fifo_count_s)
   );

   assign pop_s    = head_valid_s & m_ready;
   // A read may only go out if its word is guaranteed a FIFO slot when it returns.
   assign credit_s = (3'({1'b0, fifo_count_s}) + 3'(inflight_q)) < (3'(FIFO_DEPTH) + 3'(pop_s));

   // Sequencer next-state: command latch, read issue and completion.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      beats_d     = beats_q;
      issue_s     = 1'b0;
      if (pop_s) begin
         beats_d = beats_q - (ADDR_BITS+1)'(1);
      end else begin
         beats_d = beats_q;
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len == '0) begin
                  state_d = DONE;
               end else begin
                  state_d     = READ;
                  addr_d      = base_addr;
                  remaining_d = len;
                  beats_d     = len;
               end
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            issue_s = credit_s;
            if (issue_s) begin
               addr_d      = addr_q + ADDR_BITS'(1);
               remaining_d = remaining_q - (ADDR_BITS+1)'(1);
               if (remaining_q == (ADDR_BITS+1)'(1)) begin
                  state_d = DRAIN;
               end else begin
                  state_d = READ;
               end
            end else begin
               state_d = READ;
            end
         end
         DRAIN: begin
            if (pop_s & m_last) begin
               state_d = DONE;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      inflight_d = issue_s;
   end

   // Sequencer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         beats_q     <= '0;
         inflight_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         beats_q     <= beats_d;
         inflight_q  <= inflight_d;
      end
   end

   assign busy     = (state_q == READ) | (state_q == DRAIN);
   assign done     = (state_q == DONE);
   assign gb_wr_en = 1'b0;
   assign gb_index = addr_q;
   assign m_valid  = head_valid_s;
   assign m_data   = head_data_s;
   assign m_last   = head_valid_s & (beats_q == (ADDR_BITS+1)'(1));

endmodule

// File: tb/tb_gbuf_stream_reader.sv
// Randomized bench for gbuf_stream_reader against a queue-based reference of the word stream.
module tb_gbuf_stream_reader;

   localparam int AB    = 8;
   localparam int DB    = 8;
   localparam int DEPTH = 1 << AB;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AB-1:0] base_addr;
   logic [AB:0]   len;
   logic          busy;
   logic          done;
   logic          gb_wr_en;
   logic [AB-1:0] gb_index;
   logic [DB-1:0] gb_data_out;
   logic          m_valid;
   logic [DB-1:0] m_data;
   logic          m_last;
   logic          m_ready;

   logic [DB-1:0] mem [DEPTH];
   logic [DB-1:0] exp_q [$];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start_cyc = 0;
   int cmd_len = 0;
   int cmd_base = 0;
   int issued = 0;
   int delivered = 0;
   int done_cnt = 0;
   int done_base = 0;
   int prev_hs_cyc = 0;
   int ready_mode = 0;
   int ready_phase = 0;
   logic          stall_prev = 1'b0;
   logic          busy_prev = 1'b0;
   logic          done_prev = 1'b0;
   logic          seen_valid = 1'b0;
   logic [DB-1:0] stall_data = '0;
   logic [AB-1:0] idx_prev = '0;

   gbuf_stream_reader #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_addr   (base_addr),
      .len         (len),
      .busy        (busy),
      .done        (done),
      .gb_wr_en    (gb_wr_en),
      .gb_index    (gb_index),
      .gb_data_out (gb_data_out),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_last      (m_last),
      .m_ready     (m_ready)
   );

   always #5 clk = ~clk;

   // Global buffer model: reads every cycle with one cycle of latency.
   always @(posedge clk) gb_data_out <= mem[gb_index];

   task automatic check(input string tag, input int obs, input int expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_idle_outputs();
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_m_valid", int'(m_valid), 0);
      check("rst_m_last", int'(m_last), 0);
      check("rst_gb_index", int'(gb_index), 0);
      check("rst_gb_wr_en", int'(gb_wr_en), 0);
   endtask

   // Consumer ready pattern: always, 1-0-0 toggle, or random.
   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: m_ready = 1'b1;
            1: begin
               m_ready = ((ready_phase % 3) == 0);
               ready_phase++;
            end
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Stream monitor and scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      logic [DB-1:0] ev;
      cyc++;
      if (!rst) begin
         stall_prev = 1'b0;
         busy_prev  = 1'b0;
         done_prev  = 1'b0;
      end else begin
         check("gb_wr_en", int'(gb_wr_en), 0);
         if (stall_prev) begin
            check("stall_valid", int'(m_valid), 1);
            check("stall_data", int'(m_data), int'(stall_data));
         end
         if (m_valid && !seen_valid) begin
            seen_valid = 1'b1;
            check("first_valid_lat", cyc - start_cyc, 3);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_word", 1, 0);
            end else begin
               ev = exp_q.pop_front();
               check("data", int'(m_data), int'(ev));
               check("last", int'(m_last), int'(exp_q.size() == 0));
               if (ready_mode == 0 && delivered > 0) check("throughput", cyc - prev_hs_cyc, 1);
               prev_hs_cyc = cyc;
               delivered++;
            end
         end
         if (busy && busy_prev && gb_index != idx_prev) begin
            check("issue_addr", int'(idx_prev), (cmd_base + issued) % DEPTH);
            issued++;
         end
         if (busy) check("occupancy", int'((issued - delivered) <= 3), 1);
         if (done) begin
            done_cnt++;
            check("done_width", int'(done_prev), 0);
            check("busy_with_done", int'(busy), 0);
            check("drained_at_done", exp_q.size(), 0);
            if (cmd_len > 0) check("done_lat", cyc - prev_hs_cyc, 1);
            else check("done_len0_lat", int'((cyc - start_cyc) <= 2), 1);
         end
         stall_prev = m_valid & ~m_ready;
         stall_data = m_data;
         busy_prev  = busy;
         done_prev  = done;
         idx_prev   = gb_index;
      end
   end

   task automatic launch(input int b, input int l);
      @(posedge clk);
      #1;
      start      = 1'b1;
      base_addr  = AB'(b);
      len        = (AB+1)'(l);
      start_cyc  = cyc + 1;
      cmd_len    = l;
      cmd_base   = b;
      issued     = 0;
      delivered  = 0;
      seen_valid = 1'b0;
      done_base  = done_cnt;
      for (int k = 0; k < l; k++) exp_q.push_back(mem[(b + k) % DEPTH]);
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", int'(busy), int'(l > 0));
   endtask

   task automatic wait_done(input int budget);
      int t;
      t = 0;
      while (done_cnt == done_base && t < budget) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      check("done_count", done_cnt - done_base, 1);
      check("words_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic run_cmd(input int b, input int l);
      launch(b, l);
      wait_done(10 * l + 20);
   endtask

   initial begin
      logic [AB-1:0] idx_save;
      int dc;
      int t;
      rst       = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      len       = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = DB'(i + 1);
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);

      ready_mode = 0;
      run_cmd(4, 5);
      run_cmd(254, 4);

      ready_mode = 1;
      run_cmd(30, 6);
      ready_mode = 0;

      idx_save = gb_index;
      run_cmd(77, 0);
      check("len0_index", int'(gb_index), int'(idx_save));

      launch(10, 8);
      repeat (2) @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = AB'(100);
      len       = (AB+1)'(3);
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(100);

      launch(20, 8);
      t = 0;
      while (delivered < 2 && t < 50) begin
         @(negedge clk);
         t++;
      end
      #2;
      check("reset_beats_reached", int'(delivered >= 2), 1);
      rst = 1'b0;
      #1;
      check_idle_outputs();
      exp_q.delete();
      dc = done_cnt;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (4) @(posedge clk);
      check("no_done_after_reset", done_cnt, dc);
      run_cmd(0, 2);

      for (int i = 0; i < DEPTH; i++) mem[i] = DB'($urandom);
      ready_mode = 2;
      for (int n = 0; n < 12; n++) begin
         run_cmd($urandom_range(0, DEPTH - 1), (n == 5) ? DEPTH : $urandom_range(0, 20));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
